// File: rtl/rv32im_div_seq.sv
// Sequential RV32M divide/remainder unit.
// Restoring division, one quotient bit per cycle over 32 cycles, followed by
// a sign-fixup cycle and a single-cycle done pulse. Divide-by-zero and the
// signed overflow case (-2^31 / -1) complete immediately without iterating.
module rv32im_div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    // Dividend shift register: holds {dividend, 0} on entry; each cycle the
    // MSB feeds the partial remainder and a quotient bit enters at the LSB,
    // so after 32 cycles bits [31:0] are the quotient.
    logic [32:0] dvd_q, dvd_d;
    logic [32:0] dvsr_q, dvsr_d;
    logic [32:0] rem_q, rem_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        is_rem_q, is_rem_d;
    logic [31:0] result_q, result_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Operand conditioning for the accepting edge.
    logic        is_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        div_by_zero;
    logic        sgn_overflow;

    // One restoring step: shifted partial remainder minus divisor.
    logic [32:0] rem_shift;
    logic [33:0] trial;
    logic        q_bit;

    // Sign-corrected outputs available during FIX.
    logic [31:0] quo_fixed;
    logic [31:0] rem_fixed;

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

    // Operand decode, restoring step and sign fixup datapath.
    always_comb begin
        is_signed    = ~op[0];
        mag_a        = (is_signed && rs1[31]) ? (32'd0 - rs1) : rs1;
        mag_b        = (is_signed && rs2[31]) ? (32'd0 - rs2) : rs2;
        div_by_zero  = (rs2 == 32'd0);
        sgn_overflow = is_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);

        rem_shift = {rem_q[31:0], dvd_q[32]};
        // Extra guard bit so the borrow is visible even with rem_q[32] set.
        trial     = {rem_q[32], rem_shift} - {1'b0, dvsr_q};
        q_bit     = ~trial[33];

        quo_fixed = q_neg_q ? (32'd0 - dvd_q[31:0]) : dvd_q[31:0];
        rem_fixed = r_neg_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
    end

    // Next-state logic for the controller and all datapath registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvsr_d   = dvsr_q;
        rem_d    = rem_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        is_rem_d = is_rem_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                // flush outranks start: a killed instruction is never accepted.
                if (start && !flush) begin
                    if (div_by_zero) begin
                        state_d  = DONE;
                        result_d = op[1] ? rs1 : 32'hFFFF_FFFF;
                    end else if (sgn_overflow) begin
                        state_d  = DONE;
                        result_d = op[1] ? 32'd0 : 32'h8000_0000;
                    end else begin
                        state_d  = ITER;
                        cnt_d    = 6'd0;
                        dvd_d    = {mag_a, 1'b0};
                        dvsr_d   = {1'b0, mag_b};
                        rem_d    = 33'd0;
                        q_neg_d  = is_signed && (rs1[31] ^ rs2[31]);
                        r_neg_d  = is_signed && rs1[31];
                        is_rem_d = op[1];
                    end
                end
            end
            ITER: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d = q_bit ? trial[32:0] : rem_shift;
                    dvd_d = {dvd_q[31:0], q_bit};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    state_d  = DONE;
                    result_d = is_rem_q ? rem_fixed : quo_fixed;
                end
            end
            DONE: begin
                // The pulse is already on the output; flush cannot retract it.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ITER) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    // State and output registers; reset takes effect without a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            dvd_q    <= 33'd0;
            dvsr_q   <= 33'd0;
            rem_q    <= 33'd0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            is_rem_q <= 1'b0;
            result_q <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvsr_q   <= dvsr_d;
            rem_q    <= rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            is_rem_q <= is_rem_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_rv32im_div_seq.sv
// Directed testbench for rv32im_div_seq: normal, signed, special-case,
// flush, ignored-start and mid-operation reset scenarios.
module tb_rv32im_div_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks;
    int errors;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    rv32im_div_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op and observe 40 cycles after the accepting edge.
    // Cycle k=1 is the cycle right after the accepting edge. Optionally
    // pulses flush or a stray start (with other operands) during cycle k.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input int start_at,
                          output int lat, output int busy_cnt, output int done_cnt,
                          output logic [31:0] res, output logic busy_after_flush);
        @(negedge clk);
        op = o; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rs1 = 32'hDEAD_BEEF;
        rs2 = 32'h0000_0003;
        lat = 0; busy_cnt = 0; done_cnt = 0; busy_after_flush = 1'b1;
        res = result;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat == 0) lat = k;
                res = result;
            end
            if (k == flush_at + 1) busy_after_flush = busy;
            flush = (k == flush_at);
            start = (k == start_at);
        end
        if (done_cnt == 0) res = result;
        flush = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b result=%h, want 0 0 00000000", busy, done, result);
        end
        @(negedge clk);
        reset = 1'b1;
        $display("reset: busy=%b done=%b result=%h", busy, done, result);
    endtask

    task automatic test_unsigned;
        int lat, bc, dc; logic [31:0] res; logic bf;
        run_op(OP_DIVU, 32'd100, 32'd7, 0, 0, lat, bc, dc, res, bf);
        $display("DIVU 100/7: result=%h lat=%0d busy=%0d", res, lat, bc);
        checks++;
        if (res !== 32'd14) begin errors++; $display("FAIL divu_100_7: result=%h want 0000000e", res); end
        checks++;
        if (lat !== 34 || dc !== 1) begin errors++; $display("FAIL divu_latency: lat=%0d dones=%0d want 34 1", lat, dc); end
        checks++;
        if (bc !== 33) begin errors++; $display("FAIL divu_busy_cycles: busy=%0d want 33", bc); end

        run_op(OP_REMU, 32'd100, 32'd7, 0, 0, lat, bc, dc, res, bf);
        $display("REMU 100/7: result=%h lat=%0d", res, lat);
        checks++;
        if (res !== 32'd2 || lat !== 34) begin errors++; $display("FAIL remu_100_7: result=%h lat=%0d want 00000002 34", res, lat); end

        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 0, 0, lat, bc, dc, res, bf);
        $display("DIVU ffffffff/1: result=%h", res);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_max_by_1: result=%h want ffffffff", res); end

        run_op(OP_REMU, 32'hFFFF_FFFF, 32'h10, 0, 0, lat, bc, dc, res, bf);
        $display("REMU ffffffff/10: result=%h", res);
        checks++;
        if (res !== 32'h0000_000F) begin errors++; $display("FAIL remu_max_by_16: result=%h want 0000000f", res); end
    endtask

    task automatic test_signed;
        int lat, bc, dc; logic [31:0] res; logic bf;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, lat, bc, dc, res, bf);
        $display("DIV -7/2: result=%h lat=%0d", res, lat);
        checks++;
        if (res !== 32'hFFFF_FFFD || lat !== 34) begin errors++; $display("FAIL div_m7_2: result=%h lat=%0d want fffffffd 34", res, lat); end

        run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 0, 0, lat, bc, dc, res, bf);
        $display("REM -7/2: result=%h", res);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_m7_2: result=%h want ffffffff", res); end

        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 0, 0, lat, bc, dc, res, bf);
        $display("DIV 7/-2: result=%h", res);
        checks++;
        if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7_m2: result=%h want fffffffd", res); end

        run_op(OP_REM, 32'd7, 32'hFFFF_FFFE, 0, 0, lat, bc, dc, res, bf);
        $display("REM 7/-2: result=%h", res);
        checks++;
        if (res !== 32'd1) begin errors++; $display("FAIL rem_7_m2: result=%h want 00000001", res); end
    endtask

    task automatic test_overflow;
        int lat, bc, dc; logic [31:0] res; logic bf;
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, lat, bc, dc, res, bf);
        $display("DIV 80000000/-1: result=%h lat=%0d busy=%0d", res, lat, bc);
        checks++;
        if (res !== 32'h8000_0000 || lat !== 1 || dc !== 1) begin
            errors++; $display("FAIL div_overflow: result=%h lat=%0d dones=%0d want 80000000 1 1", res, lat, dc);
        end
        checks++;
        if (bc !== 0) begin errors++; $display("FAIL div_overflow_busy: busy=%0d want 0", bc); end

        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, lat, bc, dc, res, bf);
        $display("REM 80000000/-1: result=%h lat=%0d", res, lat);
        checks++;
        if (res !== 32'd0 || lat !== 1) begin errors++; $display("FAIL rem_overflow: result=%h lat=%0d want 00000000 1", res, lat); end
    endtask

    task automatic test_div_by_zero;
        int lat, bc, dc; logic [31:0] res; logic bf;
        run_op(OP_DIVU, 32'd5, 32'd0, 0, 0, lat, bc, dc, res, bf);
        $display("DIVU 5/0: result=%h lat=%0d", res, lat);
        checks++;
        if (res !== 32'hFFFF_FFFF || lat !== 1 || bc !== 0) begin
            errors++; $display("FAIL divu_by_zero: result=%h lat=%0d busy=%0d want ffffffff 1 0", res, lat, bc);
        end

        run_op(OP_REMU, 32'd5, 32'd0, 0, 0, lat, bc, dc, res, bf);
        $display("REMU 5/0: result=%h", res);
        checks++;
        if (res !== 32'd5 || lat !== 1) begin errors++; $display("FAIL remu_by_zero: result=%h lat=%0d want 00000005 1", res, lat); end

        run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, 0, 0, lat, bc, dc, res, bf);
        $display("DIV -5/0: result=%h", res);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_by_zero: result=%h want ffffffff", res); end

        run_op(OP_REM, 32'hFFFF_FFFB, 32'd0, 0, 0, lat, bc, dc, res, bf);
        $display("REM -5/0: result=%h", res);
        checks++;
        if (res !== 32'hFFFF_FFFB) begin errors++; $display("FAIL rem_by_zero: result=%h want fffffffb", res); end
    endtask

    task automatic test_flush;
        int lat, bc, dc; logic [31:0] res; logic bf;
        // Known prior result from an immediate op.
        run_op(OP_REMU, 32'h0000_1234, 32'd0, 0, 0, lat, bc, dc, res, bf);
        run_op(OP_DIVU, 32'd100, 32'd7, 10, 0, lat, bc, dc, res, bf);
        $display("DIVU 100/7 flushed: dones=%0d busy_after=%b result=%h", dc, bf, res);
        checks++;
        if (dc !== 0) begin errors++; $display("FAIL flush_no_done: dones=%0d want 0", dc); end
        checks++;
        if (bf !== 1'b0) begin errors++; $display("FAIL flush_busy: busy=%b want 0", bf); end
        checks++;
        if (res !== 32'h0000_1234) begin errors++; $display("FAIL flush_result_hold: result=%h want 00001234", res); end

        run_op(OP_DIVU, 32'd9, 32'd3, 0, 0, lat, bc, dc, res, bf);
        $display("DIVU 9/3 after flush: result=%h lat=%0d", res, lat);
        checks++;
        if (res !== 32'd3 || lat !== 34) begin errors++; $display("FAIL after_flush: result=%h lat=%0d want 00000003 34", res, lat); end

        // flush together with start in IDLE: nothing accepted.
        @(negedge clk);
        op = OP_DIVU; rs1 = 32'd9; rs2 = 32'd3; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        dc = 0; bc = 0;
        for (int k = 0; k < 36; k++) begin
            if (busy) bc++;
            if (done) dc++;
            @(negedge clk);
        end
        $display("start+flush in IDLE: busy=%0d dones=%0d", bc, dc);
        checks++;
        if (bc !== 0 || dc !== 0) begin errors++; $display("FAIL flush_beats_start: busy=%0d dones=%0d want 0 0", bc, dc); end
    endtask

    task automatic test_start_ignored;
        int lat, bc, dc; logic [31:0] res; logic bf;
        // Stray start in ITER (k=5), FIX (k=33) ignored; a start in DONE
        // (k=34) is also ignored, so only one done pulse appears.
        run_op(OP_DIVU, 32'd1000, 32'd10, 0, 5, lat, bc, dc, res, bf);
        $display("DIVU 1000/10 with stray start: result=%h dones=%0d", res, dc);
        checks++;
        if (res !== 32'd100 || dc !== 1 || lat !== 34) begin
            errors++; $display("FAIL start_in_iter: result=%h dones=%0d lat=%0d want 00000064 1 34", res, dc, lat);
        end
        run_op(OP_DIVU, 32'd1000, 32'd10, 0, 34, lat, bc, dc, res, bf);
        $display("DIVU 1000/10 with start in DONE: dones=%0d busy=%0d", dc, bc);
        checks++;
        if (dc !== 1 || bc !== 33) begin errors++; $display("FAIL start_in_done: dones=%0d busy=%0d want 1 33", dc, bc); end
    endtask

    task automatic test_reset_mid_op;
        int lat, bc, dc; logic [31:0] res; logic bf;
        @(negedge clk);
        op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 20; k++) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        $display("reset mid-op: busy=%b done=%b result=%h", busy, done, result);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++; $display("FAIL reset_mid_op: busy=%b done=%b result=%h want 0 0 00000000", busy, done, result);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_op(OP_DIV, 32'h8000_0000, 32'd2, 0, 0, lat, bc, dc, res, bf);
        $display("DIV 80000000/2 after reset: result=%h lat=%0d", res, lat);
        checks++;
        if (res !== 32'hC000_0000 || lat !== 34) begin errors++; $display("FAIL after_reset: result=%h lat=%0d want c0000000 34", res, lat); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        start = 1'b0;
        flush = 1'b0;
        op = 2'b00;
        rs1 = 32'd0;
        rs2 = 32'd0;
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_div_by_zero();
        test_flush();
        test_start_ignored();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32im_div_seq.md
RV32IM_DIV_SEQ -- requirements
Module: rv32im_div_seq

Interface
REQ-001 SHALL: clk  input  1  core clock; all state changes on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL: start  input  1  EX-stage request to begin a divide/remainder op; sampled only in IDLE.
REQ-004 SHALL: op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-005 SHALL: rs1  input  32  dividend; captured on the accepting edge.
REQ-006 SHALL: rs2  input  32  divisor; captured on the accepting edge.
REQ-007 SHALL: flush  input  1  pipeline kill; aborts the in-flight op.
REQ-008 SHALL: busy  output  1  registered stall request to the hazard unit.
REQ-009 SHALL: done  output  1  one-cycle pulse; result valid in the same cycle.
REQ-010 SHALL: result  output  32  quotient (DIV/DIVU) or remainder (REM/REMU).

Function
REQ-011 SHALL: FSM states are IDLE, ITER, FIX, DONE.
REQ-012 SHALL: IDLE with start=1 and flush=0 accepts the op on that edge.
- Signed ops: capture operand magnitudes, record the quotient and remainder signs.
- Unsigned ops: capture raw operands.
REQ-013 SHALL: divisor==0 on accept goes IDLE->DONE directly.
- result = 0xFFFFFFFF for DIV/DIVU; rs1 for REM/REMU.
REQ-014 SHALL: DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF goes IDLE->DONE directly.
- result = 0x80000000 for DIV; 0 for REM.
REQ-015 SHALL: otherwise IDLE->ITER; ITER runs exactly 32 cycles of restoring division, one quotient bit per cycle, MSB first, with a 6-bit iteration counter.
REQ-016 SHALL: after the 32nd ITER cycle, go ITER->FIX.
- Quotient negated iff signed op and operand signs differ.
- Remainder negated iff signed op and dividend negative.
- Load result; go FIX->DONE.
REQ-017 SHALL: DONE lasts exactly one cycle with done=1, then returns to IDLE.
REQ-018 SHALL: busy=1 exactly in ITER and FIX (33 cycles for a normal op); busy=0 in IDLE, DONE and special cases.
REQ-019 SHALL: latency from accepting edge to done: 34 cycles normal; 1 cycle special case.
REQ-020 SHALL: start is ignored in ITER, FIX and DONE; no queuing.
REQ-021 SHALL: flush=1 in ITER or FIX forces IDLE on the next edge.
- No done pulse; result keeps its prior value.
REQ-022 SHALL: flush=1 together with start=1 in IDLE: flush wins, op not accepted.
- flush in DONE does not suppress the current pulse.
REQ-023 SHALL: result holds its value between done pulses.
- Internal dividend, divisor and partial-remainder registers are 33 bits wide (sign guard for subtraction).

Reset
REQ-024 SHALL: reset=0 immediately, without a clock edge, forces IDLE, busy=0, done=0, result=0 and clears the iteration counter.
REQ-025 SHALL: reset mid-operation discards the op; the first start after reset release is accepted normally.

Verification
REQ-026 SHALL: DIVU rs1=100, rs2=7 -> done 34 cycles after accept, result=14; REMU same operands -> result=2; busy high 33 cycles.
REQ-027 SHALL: DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> result=0xFFFFFFFD; REM same operands -> result=0xFFFFFFFF.
REQ-028 SHALL: DIV rs1=0x80000000, rs2=0xFFFFFFFF -> done 1 cycle after accept, result=0x80000000, busy never high; REM same operands -> result=0.
REQ-029 SHALL: DIVU rs1=5, rs2=0 -> result=0xFFFFFFFF in 1 cycle; REMU same operands -> result=5; DIV rs1=-5, rs2=0 -> result=0xFFFFFFFF.
REQ-030 SHALL: DIVU 100/7 with flush pulsed on ITER cycle 10 -> busy=0 next cycle, no done, result unchanged; next start DIVU 9/3 -> result=3 after 34 cycles.
REQ-031 SHALL: reset driven low on ITER cycle 20 -> busy, done, result all 0 before the next clock edge; DIV 0x80000000/2 after release -> result=0xC0000000.
